fft16_reorder: RTL and testbench

FFT16_REORDER -- requirements
Module: fft16_reorder

---
 rtl/fft16_pkg.sv | 22 ++
 rtl/fft16_reorder_bank.sv | 32 +++
 rtl/fft16_reorder.sv | 201 ++++++++++++++++++++
 tb/tb_fft16_reorder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// fft16_pkg: definitions shared across the 16-point FFT chain.
//   DW           default sample component width (signed)
//   NPAIR        input pairs per 16-point frame
//   bank_state_t ping-pong bank life cycle
//   bitrev3      3-bit index bit reversal
package fft16_pkg;

   localparam int DW    = 24;
   localparam int NPAIR = 8;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_READING
   } bank_state_t;

   function automatic logic [2:0] bitrev3(input logic [2:0] k);
      return {k[0], k[1], k[2]};
   endfunction

endpackage

// File: rtl/fft16_reorder_bank.sv
// reorder_bank: one reorder buffer bank with NPAIR entries of W bits.
//   clk, rst    clock; rst clears only the read register, not the storage
//   we, waddr, wdata  write port
//   re, raddr         read request; rdata is registered and holds while re is low
module reorder_bank
#(
   parameter int W     = 96,
   parameter int DEPTH = fft16_pkg::NPAIR,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft16_reorder.sv
// fft16_reorder: converts the bit-reversed pair stream of a radix-2 16-point
// FFT into natural order using two ping-pong banks.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_first       input pair strobe, frame start (pair k=0)
//   a_r/a_i, b_r/b_i         lane A (bin bitrev3(k)), lane B (bin bitrev3(k)+8)
//   out_valid, out_ready     output handshake
//   lo_r/lo_i, hi_r/hi_i     bins m and m+8; out_idx = m; out_last at m=7
//   err_sync, err_ovf        sticky: in_first mid-frame / frame dropped for lack of a bank
module fft16_reorder
#(
   parameter int DW    = fft16_pkg::DW,
   parameter int NPAIR = fft16_pkg::NPAIR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic signed [DW-1:0] a_r,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [DW-1:0] b_r,
   input  logic signed [DW-1:0] b_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] lo_r,
   output logic signed [DW-1:0] lo_i,
   output logic signed [DW-1:0] hi_r,
   output logic signed [DW-1:0] hi_i,
   output logic [2:0]           out_idx,
   output logic                 out_last,
   output logic                 err_sync,
   output logic                 err_ovf
);

   import fft16_pkg::*;

   localparam int         PW    = 4 * DW;
   localparam logic [2:0] K_END = 3'(NPAIR - 1);

   bank_state_t bank_st  [2];
   bank_state_t bank_nxt [2];

   logic       wr_sel, wr_active, wr_drop;
   logic [2:0] k;
   logic       rd_sel, rd_busy, q_sel;
   logic [2:0] rd_m;

   logic       hs, adv, free_fire, wr_bank_empty;
   logic       wr_we, start_ok, start_drop, wr_last, sync_err;
   logic [2:0] wr_addr;
   logic       rd_issue, rd_start;
   logic [2:0] rd_addr;

   logic [PW-1:0] wdata, q0, q1, q_mux;

   assign hs        = out_valid & out_ready;
   assign adv       = ~out_valid | out_ready;
   assign free_fire = hs & out_last;
   // A bank released by this cycle's m=7 handshake is already free for a new frame.
   assign wr_bank_empty = (bank_st[wr_sel] == BANK_EMPTY) || (free_fire && (q_sel == wr_sel));

   // Writer decode
   always_comb begin
      wr_we      = 1'b0;
      wr_addr    = bitrev3(k);
      start_ok   = 1'b0;
      start_drop = 1'b0;
      wr_last    = 1'b0;
      sync_err   = 1'b0;
      if (in_valid) begin
         if (in_first) begin
            wr_addr  = '0;
            sync_err = (k != 3'd0);
            if (wr_active) begin
               wr_we = 1'b1;                  // restart in the bank already FILLING
            end else if (wr_bank_empty) begin
               wr_we    = 1'b1;
               start_ok = 1'b1;
            end else begin
               start_drop = 1'b1;
            end
         end else if (wr_active) begin
            wr_we   = 1'b1;
            wr_last = (k == K_END);
         end
      end
   end

   // Reader decode: continue the bank in progress, else take the next FULL bank.
   always_comb begin
      rd_start = adv & ~rd_busy & (bank_st[rd_sel] == BANK_FULL);
      rd_issue = adv & (rd_busy | (bank_st[rd_sel] == BANK_FULL));
      rd_addr  = rd_busy ? rd_m : 3'd0;
   end

   // Bank states; writer updates come last so a same-cycle free then refill lands on FILLING.
   always_comb begin
      bank_nxt = bank_st;
      if (free_fire) bank_nxt[q_sel]  = BANK_EMPTY;
      if (rd_start)  bank_nxt[rd_sel] = BANK_READING;
      if (start_ok)  bank_nxt[wr_sel] = BANK_FILLING;
      if (wr_last)   bank_nxt[wr_sel] = BANK_FULL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_st[0] <= BANK_EMPTY;
         bank_st[1] <= BANK_EMPTY;
      end else begin
         bank_st[0] <= bank_nxt[0];
         bank_st[1] <= bank_nxt[1];
      end
   end

   // Write counter; a dropped frame still counts its pairs so the whole frame is skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         k         <= '0;
         wr_sel    <= 1'b0;
         wr_active <= 1'b0;
         wr_drop   <= 1'b0;
         err_sync  <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         err_sync <= err_sync | sync_err;
         err_ovf  <= err_ovf | start_drop;
         if (in_valid) begin
            if (in_first) begin
               k         <= 3'd1;
               wr_active <= wr_active | start_ok;
               wr_drop   <= start_drop;
            end else if (wr_active || wr_drop) begin
               k <= k + 3'd1;
               if (k == K_END) begin
                  wr_active <= 1'b0;
                  wr_drop   <= 1'b0;
                  if (wr_active) wr_sel <= ~wr_sel;
               end
            end
         end
      end
   end

   // Reader / output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sel    <= 1'b0;
         rd_busy   <= 1'b0;
         rd_m      <= '0;
         q_sel     <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else if (adv) begin
         out_valid <= rd_issue;
         if (rd_issue) begin
            q_sel    <= rd_sel;
            out_idx  <= rd_addr;
            out_last <= (rd_addr == K_END);
            if (rd_addr == K_END) begin
               rd_busy <= 1'b0;
               rd_sel  <= ~rd_sel;
               rd_m    <= '0;
            end else begin
               rd_busy <= 1'b1;
               rd_m    <= rd_addr + 3'd1;
            end
         end
      end
   end

   assign wdata = {a_r, a_i, b_r, b_i};

   reorder_bank #(.W(PW), .DEPTH(NPAIR)) u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_we & ~wr_sel),
      .waddr (wr_addr),
      .wdata (wdata),
      .re    (rd_issue & ~rd_sel),
      .raddr (rd_addr),
      .rdata (q0)
   );

   reorder_bank #(.W(PW), .DEPTH(NPAIR)) u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_we & wr_sel),
      .waddr (wr_addr),
      .wdata (wdata),
      .re    (rd_issue & rd_sel),
      .raddr (rd_addr),
      .rdata (q1)
   );

   assign q_mux = q_sel ? q1 : q0;
   assign lo_r  = q_mux[4*DW-1 -: DW];
   assign lo_i  = q_mux[3*DW-1 -: DW];
   assign hi_r  = q_mux[2*DW-1 -: DW];
   assign hi_i  = q_mux[DW-1 -: DW];

endmodule

// File: tb/tb_fft16_reorder.sv
module tb_fft16_reorder;

   localparam int DW = 24;

   typedef struct packed {
      logic signed [DW-1:0] lo_r;
      logic signed [DW-1:0] lo_i;
      logic signed [DW-1:0] hi_r;
      logic signed [DW-1:0] hi_i;
      logic [2:0]           idx;
      logic                 last;
   } pair_t;

   logic clk = 1'b0;
   logic rst, in_valid, in_first, out_ready;
   logic out_valid, out_last, err_sync, err_ovf;
   logic signed [DW-1:0] a_r, a_i, b_r, b_i;
   logic signed [DW-1:0] lo_r, lo_i, hi_r, hi_i;
   logic [2:0] out_idx;

   fft16_reorder #(.DW(DW), .NPAIR(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .a_r       (a_r),
      .a_i       (a_i),
      .b_r       (b_r),
      .b_i       (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lo_r      (lo_r),
      .lo_i      (lo_i),
      .hi_r      (hi_r),
      .hi_i      (hi_i),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .err_sync  (err_sync),
      .err_ovf   (err_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_v = -1;
   int hs_cnt = 0;
   int hs_first = -1;
   int hs_last = -1;
   int t_last = 0;

   pair_t exp_q[$];
   pair_t prev_obs;
   logic  prev_stall = 1'b0;

   logic signed [DW-1:0] fa_r [8];
   logic signed [DW-1:0] fa_i [8];
   logic signed [DW-1:0] fb_r [8];
   logic signed [DW-1:0] fb_i [8];
   logic [2:0] br_tab [8];
   logic signed [DW-1:0] mn, mx;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic pair_t cur();
      pair_t p;
      p.lo_r = lo_r;
      p.lo_i = lo_i;
      p.hi_r = hi_r;
      p.hi_i = hi_i;
      p.idx  = out_idx;
      p.last = out_last;
      return p;
   endfunction

   task automatic check_out();
      pair_t o;
      pair_t e;
      o = cur();
      if (prev_stall) chk("stall_hold", {out_valid, o}, {1'b1, prev_obs});
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
         hs_cnt++;
         if (hs_first < 0) hs_first = cyc;
         hs_last = cyc;
         if (exp_q.size() == 0) begin
            chk("spurious_out", {1'b0, out_valid}, 2'b00);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("pair_m%0d", e.idx), o, e);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = o;
   endtask

   task automatic step();
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
      prev_stall = 1'b0;
      chk("reset_state",
          {out_valid, out_idx, out_last, lo_r, lo_i, hi_r, hi_i, err_sync, err_ovf}, '0);
   endtask

   task automatic send_pair(input int k, input logic first);
      in_valid = 1'b1; in_first = first;
      a_r = fa_r[k]; a_i = fa_i[k]; b_r = fb_r[k]; b_i = fb_i[k];
      step();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0; in_first = 1'b0;
      repeat (n) step();
   endtask

   task automatic send_frame();
      for (int k = 0; k < 8; k++) send_pair(k, k == 0);
   endtask

   task automatic load_count(input int base);
      for (int k = 0; k < 8; k++) begin
         fa_r[k] = DW'(base + k + 1);
         fa_i[k] = '0;
         fb_r[k] = DW'(base + k + 101);
         fb_i[k] = '0;
      end
   endtask

   // Output m carries the pair that entered at k = bitrev3(m).
   task automatic expect_frame();
      pair_t p;
      for (int m = 0; m < 8; m++) begin
         p.lo_r = fa_r[br_tab[m]];
         p.lo_i = fa_i[br_tab[m]];
         p.hi_r = fb_r[br_tab[m]];
         p.hi_i = fb_i[br_tab[m]];
         p.idx  = 3'(m);
         p.last = (m == 7);
         exp_q.push_back(p);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         step();
         n++;
      end
      chk("drain_done", {exp_q.size() == 0, out_valid}, 2'b10);
   endtask

   initial begin
      br_tab = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      mn = {1'b1, {(DW-1){1'b0}}};
      mx = ~mn;
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
      a_r = '0; a_i = '0; b_r = '0; b_i = '0;
      @(posedge clk);
      #1;

      // Single frame: natural-order output and two-cycle latency
      do_reset();
      load_count(0);
      expect_frame();
      first_v = -1;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) t_last = cyc;
         send_pair(k, k == 0);
      end
      drain(40);
      chk("latency", first_v, t_last + 2);

      // Four back-to-back frames, streaming without gaps
      do_reset();
      hs_cnt = 0; hs_first = -1; hs_last = -1;
      for (int f = 0; f < 4; f++) begin
         load_count(1000 * (f + 1));
         expect_frame();
         send_frame();
      end
      drain(60);
      chk("b2b_count", hs_cnt, 32);
      chk("b2b_gapless", hs_last - hs_first, 31);
      chk("b2b_flags", {err_sync, err_ovf}, 2'b00);

      // Back-pressure: third frame finds no free bank and is dropped
      do_reset();
      load_count(100);
      expect_frame();
      send_frame();
      out_ready = 1'b0;
      load_count(200);
      expect_frame();
      send_frame();
      load_count(300);
      send_pair(0, 1'b1);
      send_pair(1, 1'b0);
      out_ready = 1'b1;
      for (int k = 2; k < 8; k++) send_pair(k, 1'b0);
      drain(60);
      chk("ovf_flags", {err_sync, err_ovf}, 2'b01);

      // Stray pairs ignored; in_first at k=4 restarts the frame; gaps tolerated
      do_reset();
      load_count(900);
      send_pair(3, 1'b0);
      send_pair(4, 1'b0);
      chk("stray_no_flag", {err_sync, err_ovf, out_valid}, 3'b000);
      load_count(300);
      for (int k = 0; k < 4; k++) send_pair(k, k == 0);
      load_count(500);
      expect_frame();
      send_pair(0, 1'b1);
      idle(2);
      for (int k = 1; k < 8; k++) begin
         send_pair(k, 1'b0);
         if (k == 3) idle(1);
      end
      drain(40);
      chk("sync_flags", {err_sync, err_ovf}, 2'b10);

      // Reset mid-frame while the previous frame is being read out
      do_reset();
      load_count(600);
      expect_frame();
      send_frame();
      load_count(700);
      for (int k = 0; k < 5; k++) send_pair(k, k == 0);
      rst = 1'b1;
      send_pair(5, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      prev_stall = 1'b0;
      chk("rst_mid", {out_valid, err_sync, err_ovf}, 3'b000);
      send_pair(6, 1'b0);
      send_pair(7, 1'b0);
      idle(3);
      chk("rst_no_residue", {out_valid}, 1'b0);
      load_count(800);
      expect_frame();
      send_frame();
      drain(40);
      chk("rst_after_flags", {err_sync, err_ovf}, 2'b00);

      // Full-scale values pass bit-exact
      do_reset();
      for (int k = 0; k < 8; k++) begin
         fa_r[k] = (k % 2 == 0) ? mn : mx;
         fa_i[k] = (k % 2 == 0) ? mx : mn;
         fb_r[k] = (k % 2 == 0) ? mx : mn;
         fb_i[k] = (k % 2 == 0) ? mn : mx;
      end
      expect_frame();
      send_frame();
      drain(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
